// File: rtl/game_move_pkg.sv
// Shared types for the game move interface (move source, game core and bench).
// Move codes are 3 bits (idle gap or one of four directions); directions are 2 bits.
// code_to_dir maps a move code onto the direction driven toward the game.
package game_move_pkg;

  localparam int CODE_W = 3;
  localparam int DIR_W  = 2;

  typedef enum logic [CODE_W-1:0] {
    MV_IDLE = 3'd0,
    MV_N    = 3'd1,
    MV_S    = 3'd2,
    MV_E    = 3'd3,
    MV_W    = 3'd4
  } move_code_t;

  typedef enum logic [DIR_W-1:0] {
    N = 2'd0,
    S = 2'd1,
    E = 2'd2,
    W = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } tx_state_t;

  // Idle and illegal codes map to N so the direction bus rests at 0.
  function automatic dir_t code_to_dir(input logic [CODE_W-1:0] code);
    case (code)
      MV_S:    return S;
      MV_E:    return E;
      MV_W:    return W;
      default: return N;
    endcase
  endfunction

  function automatic logic code_is_move(input logic [CODE_W-1:0] code);
    return (code >= MV_N) && (code <= MV_W);
  endfunction

  function automatic logic code_is_legal(input logic [CODE_W-1:0] code);
    return code <= MV_W;
  endfunction

endpackage

// File: rtl/game_move_buf.sv
// Script buffer: DEPTH x CODE_W circular store with count, full/empty and flush.
// Latency: a write is visible at the head one cycle later; head and head+1 are read combinationally.
// Backpressure: none internally; the owner must not write when full or pop when empty.
// Ports: i_clock/i_reset, i_flush (clears pointers and count), i_wr_vld/i_wr_dat (push),
//   i_rd_pop (advance head), o_head_dat/o_next_dat (entries at rd_ptr and rd_ptr+1),
//   o_count, o_full, o_empty.
module game_move_buf
  import game_move_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_flush,
  input  logic                     i_wr_vld,
  input  logic [CODE_W-1:0]        i_wr_dat,
  input  logic                     i_rd_pop,
  output logic [CODE_W-1:0]        o_head_dat,
  output logic [CODE_W-1:0]        o_next_dat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_MAX = DEPTH[PTR_W:0];

  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;

  assign w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;

  // Storage carries no reset; stale entries are never read because count gates playback.
  always_ff @(posedge i_clock) begin
    if (i_wr_vld && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_vld) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_rd_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({i_wr_vld, i_rd_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_next_dat = r_mem[w_rd_ptr_nxt];
  assign o_count    = r_count;
  assign o_full     = (r_count == CNT_MAX);
  assign o_empty    = (r_count == '0);

endmodule

// File: rtl/game_move_tx.sv
// Move source: buffers a script of move codes, then plays it into the game one move per handshake.
// Latency: first move valid the cycle after start; one move per cycle with mv_ready high; IDLE_CYCLES low per gap code.
// Backpressure: mv_valid/mv_dir held until mv_ready; load_ready drops when full or not loading.
// Ports: clock/reset; load_valid/load_code/load_ready script input; start/abort control;
//   busy/done status; mv_valid/mv_dir/mv_ready move output; moves_sent counter; code_err sticky flag.
module game_move_tx
  import game_move_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int IDLE_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [CODE_W-1:0] load_code,
  output logic              load_ready,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mv_valid,
  output logic [DIR_W-1:0]  mv_dir,
  input  logic              mv_ready,
  output logic [CNT_W-1:0]  moves_sent,
  output logic              code_err
);

  localparam int BCNT_W = $clog2(DEPTH) + 1;
  localparam int GAP_W  = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(IDLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE   = 1;
  localparam logic [CNT_W-1:0]  MOVES_ONE = 1;
  localparam logic [BCNT_W-1:0] BUF_ONE   = 1;
  localparam logic              ONE_IDLE  = (IDLE_CYCLES == 1);

  tx_state_t          r_state;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_mv_valid;
  dir_t               r_mv_dir;
  logic               r_done;
  logic [CNT_W-1:0]   r_moves_sent;
  logic               r_code_err;

  logic [CODE_W-1:0]  w_head;
  logic [CODE_W-1:0]  w_next;
  logic [CODE_W-1:0]  w_start_head;
  logic [BCNT_W-1:0]  w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_load_acc;
  logic               w_legal;
  logic               w_wr;
  logic               w_hs;
  logic               w_pop;
  logic               w_flush;
  logic               w_last;

  assign load_ready   = (r_state == LOAD) && !w_full;
  assign w_load_acc   = load_valid && load_ready;
  assign w_legal      = code_is_legal(load_code);
  assign w_wr         = w_load_acc && w_legal;
  assign w_hs         = r_mv_valid && mv_ready;
  assign w_flush      = abort || (r_state == DONE);
  assign w_last       = (w_count == BUF_ONE);
  // An empty buffer started together with a load plays the code being written.
  assign w_start_head = w_empty ? load_code : w_head;

  // Pop when the head move is taken, or when an idle entry's gap has elapsed.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      PLAY:    w_pop = code_is_move(w_head) ? w_hs : ONE_IDLE;
      GAP:     w_pop = (r_gap_cnt == GAP_ONE);
      default: w_pop = 1'b0;
    endcase
  end

  game_move_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_flush    (w_flush),
    .i_wr_vld   (w_wr),
    .i_wr_dat   (load_code),
    .i_rd_pop   (w_pop),
    .o_head_dat (w_head),
    .o_next_dat (w_next),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // mv_valid/mv_dir are registered with a one-entry lookahead (head+1 on pop) so the
  // next move appears the cycle after a handshake without any path from mv_ready.
  // The PLAY cycle on an idle entry is the first low cycle of the gap, so GAP
  // itself lasts IDLE_CYCLES-1 cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= LOAD;
      r_gap_cnt    <= '0;
      r_mv_valid   <= 1'b0;
      r_mv_dir     <= N;
      r_done       <= 1'b0;
      r_moves_sent <= '0;
      r_code_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_hs && (r_moves_sent != '1)) begin
        r_moves_sent <= r_moves_sent + MOVES_ONE;
      end
      if (w_load_acc && !w_legal) begin
        r_code_err <= 1'b1;
      end
      if (abort) begin
        r_state    <= LOAD;
        r_mv_valid <= 1'b0;
        r_mv_dir   <= N;
      end else begin
        case (r_state)
          LOAD: begin
            if (start) begin
              if (!w_empty || w_wr) begin
                r_state    <= PLAY;
                r_mv_valid <= code_is_move(w_start_head);
                r_mv_dir   <= code_to_dir(w_start_head);
              end else begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end
          end
          PLAY, GAP: begin
            if (w_pop) begin
              if (w_last) begin
                r_state    <= DONE;
                r_done     <= 1'b1;
                r_mv_valid <= 1'b0;
                r_mv_dir   <= N;
              end else begin
                r_state    <= PLAY;
                r_mv_valid <= code_is_move(w_next);
                r_mv_dir   <= code_to_dir(w_next);
              end
            end else if ((r_state == PLAY) && !code_is_move(w_head)) begin
              r_state   <= GAP;
              r_gap_cnt <= GAP_LOAD;
            end else if (r_state == GAP) begin
              r_gap_cnt <= r_gap_cnt - GAP_ONE;
            end
          end
          DONE:    r_state <= LOAD;
          default: r_state <= LOAD;
        endcase
      end
    end
  end

  assign busy       = (r_state == PLAY) || (r_state == GAP);
  assign done       = r_done;
  assign mv_valid   = r_mv_valid;
  assign mv_dir     = r_mv_dir;
  assign moves_sent = r_moves_sent;
  assign code_err   = r_code_err;

endmodule

// File: tb/tb_game_move_tx.sv
// Bench for game_move_tx: directed scripts; expected moves and gap lengths are queued at load time
// and a monitor process pops and compares them on every handshake.
// Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
module tb_game_move_tx;
  import game_move_pkg::*;

  localparam int IDLE = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             load_valid = 1'b0;
  logic [2:0]       load_code = 3'd0;
  logic             load_ready;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             busy;
  logic             done;
  logic             mv_valid;
  logic [1:0]       mv_dir;
  logic             mv_ready = 1'b1;
  logic [7:0]       moves_sent;
  logic             code_err;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int low_cnt = 0;
  int exp_dir_q[$];
  int exp_gap_q[$];

  game_move_tx #(.DEPTH(16), .IDLE_CYCLES(IDLE), .CNT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_code  (load_code),
    .load_ready (load_ready),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .mv_valid   (mv_valid),
    .mv_dir     (mv_dir),
    .mv_ready   (mv_ready),
    .moves_sent (moves_sent),
    .code_err   (code_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic load_one(input logic [2:0] c);
    int guard = 0;
    load_valid = 1'b1;
    load_code  = c;
    @(negedge clock);
    while (!load_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!load_ready) chk("load_timeout", 0, 1);
    @(posedge clock); #1;
    load_valid = 1'b0;
  endtask

  // Loads a script; when expect_out is set, each move's direction and the number of
  // low cycles that must precede it (IDLE per preceding '_') are queued.
  task automatic load_script(input string s, input bit expect_out);
    int idles = 0;
    for (int i = 0; i < s.len(); i++) begin
      logic [2:0] c;
      int d;
      d = -1;
      case (s[i])
        "N":     begin c = MV_N; d = 0; end
        "S":     begin c = MV_S; d = 1; end
        "E":     begin c = MV_E; d = 2; end
        "W":     begin c = MV_W; d = 3; end
        "6":     c = 3'd6;
        default: c = MV_IDLE;
      endcase
      load_one(c);
      if (c == MV_IDLE) idles++;
      if (d >= 0 && expect_out) begin
        exp_dir_q.push_back(d);
        exp_gap_q.push_back(idles * IDLE);
        idles = 0;
      end
    end
  endtask

  task automatic start_play();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_moves(input int n);
    for (int i = 0; i < 300; i++) begin
      if (int'(moves_sent) == n) break;
      @(posedge clock); #1;
    end
    chk("wait_moves", moves_sent, n);
  endtask

  task automatic settle_check(input string tag, input int moves, input int dones);
    repeat (2) @(posedge clock);
    #1;
    chk({tag, "_moves_sent"}, moves_sent, moves);
    chk({tag, "_done_cnt"}, done_cnt, dones);
    chk({tag, "_load_ready"}, load_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_queue_empty"}, exp_dir_q.size(), 0);
  endtask

  initial begin
    fork
      begin : monitor
        bit held_prev = 1'b0;
        int held_dir = 0;
        forever begin
          @(negedge clock);
          if (reset) begin
            held_prev = 1'b0;
            low_cnt = 0;
          end else begin
            if (done) done_cnt++;
            if (mv_valid) begin
              if (held_prev) chk("hold_dir", mv_dir, held_dir);
              if (mv_ready) begin
                if (exp_dir_q.size() == 0) begin
                  chk("extra_move", 1, 0);
                end else begin
                  chk("mv_dir", mv_dir, exp_dir_q.pop_front());
                  chk("gap_len", low_cnt, exp_gap_q.pop_front());
                end
                held_prev = 1'b0;
              end else begin
                held_prev = 1'b1;
                held_dir = mv_dir;
              end
              low_cnt = 0;
            end else begin
              held_prev = 1'b0;
              if (busy) begin
                chk("dir_idle_zero", mv_dir, 0);
                low_cnt++;
              end
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mv_valid", mv_valid, 0);
    chk("rst_mv_dir", mv_dir, 0);
    chk("rst_moves_sent", moves_sent, 0);
    chk("rst_code_err", code_err, 0);

    // 1: back-to-back moves, one per cycle from the cycle after start
    load_script("EWESNSE", 1'b1);
    start_play();
    chk("t1_first_valid", mv_valid, 1);
    chk("t1_first_dir", mv_dir, 2);
    wait_done();
    settle_check("t1", 7, 1);

    // 2: idle gaps of IDLE low cycles before each move
    load_script("_E_S_W_E_E", 1'b1);
    start_play();
    chk("t2_busy", busy, 1);
    chk("t2_gap_low", mv_valid, 0);
    wait_done();
    settle_check("t2", 12, 2);

    // 3: backpressure holds N for three cycles
    mv_ready = 1'b0;
    load_script("NS", 1'b1);
    start_play();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge clock); #1;
      end
      chk("t3_hold_valid", mv_valid, 1);
      chk("t3_hold_dir", mv_dir, 0);
    end
    mv_ready = 1'b1;
    wait_done();
    settle_check("t3", 14, 3);

    // 4: full buffer refuses the 17th code until playback finishes
    load_script("NSEWNSEWNSEWNSEW", 1'b1);
    chk("t4_full_ready", load_ready, 0);
    load_valid = 1'b1;
    load_code  = MV_W;
    repeat (3) @(posedge clock);
    #1;
    chk("t4_held_ready", load_ready, 0);
    start_play();
    chk("t4_play_ready", load_ready, 0);
    chk("t4_play_busy", busy, 1);
    wait_done();
    chk("t4_16_moves", moves_sent, 30);
    exp_dir_q.push_back(3);
    exp_gap_q.push_back(0);
    chk("t4_ready_again", load_ready, 1);
    @(posedge clock); #1;
    load_valid = 1'b0;
    start_play();
    wait_done();
    settle_check("t4", 31, 5);

    // 5: illegal code is swallowed and flagged
    load_script("N", 1'b1);
    chk("t5_err_before", code_err, 0);
    load_script("6", 1'b1);
    chk("t5_err_set", code_err, 1);
    load_script("E", 1'b1);
    start_play();
    wait_done();
    chk("t5_err_sticky", code_err, 1);
    settle_check("t5", 33, 6);

    // 6a: abort after three moves, then a fresh script
    load_script("EWESNSE", 1'b1);
    start_play();
    wait_moves(36);
    abort = 1'b1;
    mv_ready = 1'b0;
    @(posedge clock); #1;
    abort = 1'b0;
    mv_ready = 1'b1;
    chk("t6_abort_valid", mv_valid, 0);
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_left", exp_dir_q.size(), 4);
    exp_dir_q.delete();
    exp_gap_q.delete();
    settle_check("t6_abort", 36, 6);
    load_script("NW", 1'b1);
    start_play();
    wait_done();
    settle_check("t6_after_abort", 38, 7);

    // 6b: reset while in a gap
    load_script("_N", 1'b0);
    start_play();
    repeat (2) @(posedge clock);
    #1;
    chk("t6_gap_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", mv_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_moves", moves_sent, 0);
    chk("t6_rst_err", code_err, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    settle_check("t6_rst", 0, 7);
    load_script("SE", 1'b1);
    start_play();
    chk("t6_first_dir", mv_dir, 1);
    wait_done();
    settle_check("t6_after_rst", 2, 8);
    chk("gap_queue_empty", exp_gap_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
